ft600_fifo_responder: RTL and testbench

Synthesizable model of the FT600 chip side of the 245-synchronous FIFO bus. It answers the FPGA bus master: drives `o_ft_rxf_n`/`o_ft_txe_n`, presents host-to-FPGA words on the data bus while `i_ft_oe_n` is low, and captures FPGA-to-host words while `i_ft_wr_n` is low. A host-side valid/ready stream feeds and drains it. The block is used as the loopback partner for the FT600 FIFO/ADC top in simulation and on-chip self-test builds.

---
 rtl/ft600_pkg.sv | 19 +
 rtl/ft_sync_fifo.sv | 49 ++++
 rtl/ft600_fifo_responder.sv | 112 +++++++++++
 tb/tb_ft600_fifo_responder.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ft600_pkg.sv
// rtl/ft600_pkg.sv - shared widths, command opcodes and error bit indices for the FT600 blocks
package ft600_pkg;

  localparam int DATA_W = 16;
  localparam int BE_W   = DATA_W / 8;

  localparam logic [7:0] CMD_LEN_LO   = 8'd1;
  localparam logic [7:0] CMD_LEN_HI   = 8'd2;
  localparam logic [7:0] CMD_WR_CNT   = 8'd3;
  localparam logic [7:0] CMD_LOOPBACK = 8'd7;
  localparam logic [7:0] CMD_LED      = 8'd8;
  localparam logic [7:0] CMD_ADC      = 8'd10;

  localparam int ERR_UNDERRUN   = 0;
  localparam int ERR_OVERFLOW   = 1;
  localparam int ERR_CONTENTION = 2;
  localparam int ERR_W          = 3;

endpackage

// File: rtl/ft_sync_fifo.sv
// rtl/ft_sync_fifo.sv - first-word-fall-through synchronous queue with level/full/empty
module ft_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign head    = mem[rd_ptr[AW-1:0]];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Storage array; contents are only meaningful between rd_ptr and wr_ptr.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // Pointers wrap naturally; reset empties the queue at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/ft600_fifo_responder.sv
// rtl/ft600_fifo_responder.sv - FT600 chip-side responder for the 245 synchronous FIFO bus
module ft600_fifo_responder #(
  parameter int DATA_W = 16,
  parameter int BE_W   = DATA_W / 8,
  parameter int DEPTH  = 16
) (
  input  logic                   i_ft_clk,
  input  logic                   rst,
  input  logic                   i_ft_oe_n,
  input  logic                   i_ft_rd_n,
  input  logic                   i_ft_wr_n,
  input  logic [DATA_W-1:0]      i_ft_data,
  input  logic [BE_W-1:0]        i_ft_be,
  output logic [DATA_W-1:0]      o_ft_data,
  output logic [BE_W-1:0]        o_ft_be,
  output logic                   o_ft_drive,
  output logic                   o_ft_rxf_n,
  output logic                   o_ft_txe_n,
  input  logic                   i_h2f_valid,
  output logic                   o_h2f_ready,
  input  logic [DATA_W-1:0]      i_h2f_data,
  output logic                   o_f2h_valid,
  input  logic                   i_f2h_ready,
  output logic [DATA_W-1:0]      o_f2h_data,
  output logic [BE_W-1:0]        o_f2h_be,
  output logic [$clog2(DEPTH):0] o_h2f_level,
  output logic [$clog2(DEPTH):0] o_f2h_level,
  output logic [2:0]             o_err
);

  import ft600_pkg::*;

  localparam int LW = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0]      h2f_head;
  logic                   h2f_full;
  logic                   h2f_empty;
  logic                   h2f_push;
  logic                   h2f_pop;
  logic [BE_W+DATA_W-1:0] f2h_head;
  logic                   f2h_full;
  logic                   f2h_empty;
  logic                   f2h_push;
  logic                   f2h_pop;
  logic                   contention;
  logic [LW-1:0]          h2f_level_nxt;
  logic [LW-1:0]          f2h_level_nxt;
  logic [2:0]             err_set;

  // Write is refused whenever it collides with a read strobe or with the responder driving the bus.
  assign contention = ~i_ft_wr_n & (~i_ft_rd_n | ~i_ft_oe_n);
  assign h2f_push   = i_h2f_valid & o_h2f_ready;
  assign h2f_pop    = ~i_ft_rd_n & ~i_ft_oe_n & ~o_ft_rxf_n;
  assign f2h_push   = ~i_ft_wr_n & ~o_ft_txe_n & ~contention;
  assign f2h_pop    = o_f2h_valid & i_f2h_ready;

  assign o_h2f_ready = ~h2f_full;
  assign o_f2h_valid = ~f2h_empty;
  assign o_ft_drive  = ~i_ft_oe_n;
  assign o_ft_data   = h2f_empty ? '0 : h2f_head;
  assign o_ft_be     = h2f_empty ? '0 : {BE_W{1'b1}};
  assign o_f2h_data  = f2h_head[DATA_W-1:0];
  assign o_f2h_be    = f2h_head[BE_W+DATA_W-1:DATA_W];

  ft_sync_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH)) u_h2f (
    .clk       (i_ft_clk),
    .rst       (rst),
    .push      (h2f_push),
    .push_data (i_h2f_data),
    .pop       (h2f_pop),
    .head      (h2f_head),
    .level     (o_h2f_level),
    .full      (h2f_full),
    .empty     (h2f_empty)
  );

  ft_sync_fifo #(.WIDTH(BE_W + DATA_W), .DEPTH(DEPTH)) u_f2h (
    .clk       (i_ft_clk),
    .rst       (rst),
    .push      (f2h_push),
    .push_data ({i_ft_be, i_ft_data}),
    .pop       (f2h_pop),
    .head      (f2h_head),
    .level     (o_f2h_level),
    .full      (f2h_full),
    .empty     (f2h_empty)
  );

  // Post-edge occupancy and the protocol violations seen at this edge.
  always_comb begin
    h2f_level_nxt = o_h2f_level + LW'(h2f_push) - LW'(h2f_pop);
    f2h_level_nxt = o_f2h_level + LW'(f2h_push) - LW'(f2h_pop);
    err_set = '0;
    err_set[ERR_UNDERRUN]   = ~i_ft_rd_n & o_ft_rxf_n;
    err_set[ERR_OVERFLOW]   = ~i_ft_wr_n & o_ft_txe_n;
    err_set[ERR_CONTENTION] = contention;
  end

  // Registered bus flags track the queues after this edge; errors are sticky until reset.
  always_ff @(posedge i_ft_clk or posedge rst) begin
    if (rst) begin
      o_ft_rxf_n <= 1'b1;
      o_ft_txe_n <= 1'b0;
      o_err      <= '0;
    end else begin
      o_ft_rxf_n <= (h2f_level_nxt == '0);
      o_ft_txe_n <= (f2h_level_nxt == LW'(DEPTH));
      o_err      <= o_err | err_set;
    end
  end

endmodule

// File: tb/tb_ft600_fifo_responder.sv
// tb/tb_ft600_fifo_responder.sv - directed vector bench for ft600_fifo_responder
module tb_ft600_fifo_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        oe_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
  logic [15:0] ft_din = '0;
  logic [1:0]  ft_bein = 2'b11;
  logic [15:0] ft_dout;
  logic [1:0]  ft_beout;
  logic        drive, rxf_n, txe_n;
  logic        h2f_valid = 1'b0, h2f_ready;
  logic [15:0] h2f_data = '0;
  logic        f2h_valid, f2h_ready = 1'b0;
  logic [15:0] f2h_data;
  logic [1:0]  f2h_be;
  logic [4:0]  h2f_level, f2h_level;
  logic [2:0]  err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ft600_fifo_responder #(.DATA_W(16), .BE_W(2), .DEPTH(16)) dut (
    .i_ft_clk    (clk),
    .rst         (rst),
    .i_ft_oe_n   (oe_n),
    .i_ft_rd_n   (rd_n),
    .i_ft_wr_n   (wr_n),
    .i_ft_data   (ft_din),
    .i_ft_be     (ft_bein),
    .o_ft_data   (ft_dout),
    .o_ft_be     (ft_beout),
    .o_ft_drive  (drive),
    .o_ft_rxf_n  (rxf_n),
    .o_ft_txe_n  (txe_n),
    .i_h2f_valid (h2f_valid),
    .o_h2f_ready (h2f_ready),
    .i_h2f_data  (h2f_data),
    .o_f2h_valid (f2h_valid),
    .i_f2h_ready (f2h_ready),
    .o_f2h_data  (f2h_data),
    .o_f2h_be    (f2h_be),
    .o_h2f_level (h2f_level),
    .o_f2h_level (f2h_level),
    .o_err       (err)
  );

  typedef struct {
    logic        hv;
    logic [15:0] hd;
    logic        oe_n, rd_n, wr_n;
    logic [15:0] fd;
    logic        fr;
    logic        e_rxf_n, e_txe_n;
    logic [15:0] e_data;
    logic [4:0]  e_hl, e_fl;
    logic [2:0]  e_err;
    logic        e_fv;
    logic [15:0] e_fdata;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    h2f_valid = 1'b0; oe_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; f2h_ready = 1'b0; ft_bein = 2'b11;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    //          hv  hd        oe rd wr fd        fr  rxf txe data      hl fl err   fv fdata
    vecs[0]  = '{1, 16'h7ABC, 1, 1, 1, 16'h0000, 0,  0, 0, 16'h7ABC, 1, 0, 3'b000, 0, 16'h0000};
    vecs[1]  = '{0, 16'h0000, 0, 1, 1, 16'h0000, 0,  0, 0, 16'h7ABC, 1, 0, 3'b000, 0, 16'h0000};
    vecs[2]  = '{0, 16'h0000, 0, 0, 1, 16'h0000, 0,  1, 0, 16'h0000, 0, 0, 3'b000, 0, 16'h0000};
    vecs[3]  = '{0, 16'h0000, 0, 0, 1, 16'h0000, 0,  1, 0, 16'h0000, 0, 0, 3'b001, 0, 16'h0000};
    vecs[4]  = '{0, 16'h0000, 1, 1, 0, 16'h1234, 0,  1, 0, 16'h0000, 0, 1, 3'b001, 1, 16'h1234};
    vecs[5]  = '{0, 16'h0000, 0, 1, 0, 16'h5555, 0,  1, 0, 16'h0000, 0, 1, 3'b101, 1, 16'h1234};
    vecs[6]  = '{0, 16'h0000, 1, 1, 1, 16'h0000, 1,  1, 0, 16'h0000, 0, 0, 3'b101, 0, 16'h0000};
    vecs[7]  = '{1, 16'h0011, 1, 1, 1, 16'h0000, 0,  0, 0, 16'h0011, 1, 0, 3'b101, 0, 16'h0000};
    vecs[8]  = '{1, 16'h0022, 0, 0, 1, 16'h0000, 0,  0, 0, 16'h0022, 1, 0, 3'b101, 0, 16'h0000};
    vecs[9]  = '{0, 16'h0000, 0, 0, 1, 16'h0000, 0,  1, 0, 16'h0000, 0, 0, 3'b101, 0, 16'h0000};
    vecs[10] = '{0, 16'h0000, 1, 1, 0, 16'h00A5, 1,  1, 0, 16'h0000, 0, 1, 3'b101, 1, 16'h00A5};
    vecs[11] = '{0, 16'h0000, 1, 1, 0, 16'h00A6, 1,  1, 0, 16'h0000, 0, 1, 3'b101, 1, 16'h00A6};

    // Reset values, both while asserted and just after release.
    idle();
    step();
    check("in_reset", {rxf_n, txe_n, h2f_ready, f2h_valid, h2f_level, f2h_level, err, ft_dout},
          {1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 3'b000, 16'h0000});
    do_reset();
    check("reset_state", {rxf_n, txe_n, h2f_ready, f2h_valid, h2f_level, f2h_level, err, ft_dout, ft_beout},
          {1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 3'b000, 16'h0000, 2'b00});

    // Table of single-edge vectors starting from reset.
    for (int i = 0; i < 12; i++) begin
      h2f_valid = vecs[i].hv; h2f_data = vecs[i].hd;
      oe_n = vecs[i].oe_n; rd_n = vecs[i].rd_n; wr_n = vecs[i].wr_n;
      ft_din = vecs[i].fd; f2h_ready = vecs[i].fr; ft_bein = 2'b11;
      step();
      check($sformatf("vec%0d", i),
            {rxf_n, txe_n, ft_dout, ft_beout, drive, h2f_level, f2h_level, err, f2h_valid,
             (f2h_valid ? f2h_data : 16'h0000)},
            {vecs[i].e_rxf_n, vecs[i].e_txe_n, vecs[i].e_data, (vecs[i].e_hl != 0) ? 2'b11 : 2'b00,
             ~vecs[i].oe_n, vecs[i].e_hl, vecs[i].e_fl, vecs[i].e_err, vecs[i].e_fv,
             (vecs[i].e_fv ? vecs[i].e_fdata : 16'h0000)});
    end

    // Zero-wait burst: master keeps rd_n low whenever rxf_n is low while 16 words stream in.
    begin
      int pushed = 0, popped = 0, cyc = 0;
      do_reset();
      oe_n = 1'b0;
      while (popped < 16 && cyc < 40) begin
        h2f_valid = (pushed < 16);
        h2f_data  = 16'(pushed);
        rd_n      = rxf_n;
        if (!rd_n) begin
          check("burst_word", ft_dout, 64'(popped));
          popped++;
        end
        if (h2f_valid && h2f_ready) pushed++;
        step();
        cyc++;
      end
      idle();
      check("burst_pops", popped, 16);
      check("burst_cycles", cyc, 17);
      check("burst_end", {err, h2f_level, rxf_n}, {3'b000, 5'd0, 1'b1});
    end

    // F2H fill without draining, then an overflowing 17th write, then drain in order.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      wr_n = 1'b0; ft_din = 16'h0100 + 16'(i); ft_bein = 2'(i);
      step();
    end
    check("full_flags", {txe_n, f2h_level, err}, {1'b1, 5'd16, 3'b000});
    ft_din = 16'hDEAD;
    step();
    check("overflow", {err, f2h_level}, {3'b010, 5'd16});
    wr_n = 1'b1;
    f2h_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("drain_word", {f2h_valid, f2h_be, f2h_data}, {1'b1, 2'(i), 16'h0100 + 16'(i)});
      step();
    end
    check("drained", {f2h_valid, f2h_level, txe_n}, {1'b0, 5'd0, 1'b0});
    idle();

    // rd_n and wr_n low together with H2F empty: underrun plus contention, write dropped.
    do_reset();
    rd_n = 1'b0; wr_n = 1'b0; ft_din = 16'h4321;
    step();
    idle();
    check("rdwr_contention", {err, f2h_level, h2f_level}, {3'b101, 5'd0, 5'd0});

    // Loopback-style capture of four words with full byte enables.
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      wr_n = 1'b0; ft_din = 16'(i); ft_bein = 2'b11;
      step();
    end
    wr_n = 1'b1;
    f2h_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("loop_word", {f2h_valid, f2h_be, f2h_data}, {1'b1, 2'b11, 16'(i)});
      step();
    end
    idle();

    // Asynchronous reset with both queues occupied, then normal traffic afterwards.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      h2f_valid = 1'b1; h2f_data = 16'h0200 + 16'(i);
      wr_n = (i < 3) ? 1'b0 : 1'b1; ft_din = 16'h0300 + 16'(i);
      step();
    end
    idle();
    check("pre_reset_levels", {h2f_level, f2h_level, rxf_n}, {5'd5, 5'd3, 1'b0});
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", {h2f_level, f2h_level, rxf_n, f2h_valid}, {5'd0, 5'd0, 1'b1, 1'b0});
    step();
    rst = 1'b0;
    h2f_valid = 1'b1; h2f_data = 16'hBEEF;
    step();
    h2f_valid = 1'b0; oe_n = 1'b0;
    #1;
    check("after_reset_word", {rxf_n, ft_dout, drive}, {1'b0, 16'hBEEF, 1'b1});
    rd_n = 1'b0;
    step();
    idle();
    check("after_reset_pop", {rxf_n, h2f_level, err}, {1'b1, 5'd0, 3'b000});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
